usi_bus_fabric: RTL

//  Parametrised USI bus fabric between one master (MCB) and pSlaveNum peripheral blocks.

---
 rtl/usi_bus_fabric.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/usi_bus_fabric.sv
// USI bus fabric: decodes the master address to one of pSlaveNum peripheral blocks,
// issues one-hot write/read strobes and closes every transaction with Vd (plus Err on miss/timeout).
module usi_bus_fabric #(
    parameter int                  pSlaveNum  = 9,
    parameter int                  pDataBit   = 32,
    parameter int                  pAdrsBit   = 16,
    parameter int                  pBlockBit  = 8,
    parameter int                  pBlockBase = 1,
    parameter int                  pTimeout   = 255,
    parameter logic [pDataBit-1:0] pErrData   = 32'hDEADBEEF
) (
    input  logic                          iUsiClk,
    input  logic                          iUsiRst,
    input  logic [pDataBit-1:0]           iMUsiWd,
    input  logic [pAdrsBit-1:0]           iMUsiAdrs,
    input  logic                          iMUsiWCke,
    input  logic                          iMUsiRCke,
    output logic [pDataBit-1:0]           oMUsiRd,
    output logic                          oMUsiVd,
    output logic                          oMUsiErr,
    output logic                          oMUsiBusy,
    output logic [pDataBit-1:0]           oSUsiWd,
    output logic [pAdrsBit-1:0]           oSUsiAdrs,
    output logic [pSlaveNum-1:0]          oSUsiWCke,
    output logic [pSlaveNum-1:0]          oSUsiRCke,
    input  logic [pDataBit*pSlaveNum-1:0] iSUsiRd,
    input  logic [pSlaveNum-1:0]          iSUsiVd
);
    localparam int cIdxBit = (pSlaveNum > 1) ? $clog2(pSlaveNum) : 1;
    localparam int cCntBit = $clog2(pTimeout + 1);
    localparam logic [cCntBit-1:0] cCntLast = cCntBit'(pTimeout - 1);

    typedef enum logic [2:0] {
        IDLE,
        WSTB,
        RSTB,
        RWAIT,
        DONE,
        ERR
    } state_t;

    state_t               stateReg, stateNext;
    logic [cIdxBit-1:0]   idxReg, idxNext;
    logic [cCntBit-1:0]   cntReg, cntNext;
    logic [pDataBit-1:0]  rdReg, rdNext;
    logic [pDataBit-1:0]  wdReg;
    logic [pAdrsBit-1:0]  adrsReg;
    logic                 accept;

    // Block decode on the live master address
    logic [pBlockBit-1:0] blockId;
    logic                 blockHit;
    logic [cIdxBit-1:0]   blockIdx;

    assign blockId  = iMUsiAdrs[pAdrsBit-1 -: pBlockBit];
    assign blockHit = (32'(blockId) >= 32'(pBlockBase)) &&
                      (32'(blockId) <  32'(pBlockBase + pSlaveNum));
    assign blockIdx = cIdxBit'(blockId - pBlockBit'(pBlockBase));

    logic [pDataBit-1:0] slaveRd [pSlaveNum];
    logic                selVd;

    generate
        for (genvar gi = 0; gi < pSlaveNum; gi++) begin : gSlave
            assign slaveRd[gi]   = iSUsiRd[gi*pDataBit +: pDataBit];
            assign oSUsiWCke[gi] = (stateReg == WSTB) && (idxReg == cIdxBit'(gi));
            assign oSUsiRCke[gi] = (stateReg == RSTB) && (idxReg == cIdxBit'(gi));
        end
    endgenerate

    assign selVd = iSUsiVd[idxReg];

    always_comb begin
        stateNext = stateReg;
        idxNext   = idxReg;
        cntNext   = cntReg;
        rdNext    = rdReg;
        accept    = 1'b0;
        case (stateReg)
            IDLE: begin
                if (iMUsiWCke || iMUsiRCke) begin
                    accept  = 1'b1;
                    idxNext = blockIdx;
                    if (!blockHit) begin
                        stateNext = ERR;
                        // write wins a collision, so only a pure read miss loads the error word
                        if (!iMUsiWCke) begin
                            rdNext = pErrData;
                        end
                    end else begin
                        stateNext = iMUsiWCke ? WSTB : RSTB;
                    end
                end
            end
            WSTB: stateNext = DONE;
            RSTB: begin
                stateNext = RWAIT;
                cntNext   = '0;
            end
            RWAIT: begin
                if (selVd) begin
                    rdNext    = slaveRd[idxReg];
                    stateNext = DONE;
                end else if (cntReg == cCntLast) begin
                    rdNext    = pErrData;
                    stateNext = ERR;
                end else begin
                    cntNext = cntReg + 1'b1;
                end
            end
            DONE:    stateNext = IDLE;
            ERR:     stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge iUsiClk) begin
        if (iUsiRst) begin
            stateReg <= IDLE;
            idxReg   <= '0;
            cntReg   <= '0;
            rdReg    <= '0;
            wdReg    <= '0;
            adrsReg  <= '0;
        end else begin
            stateReg <= stateNext;
            idxReg   <= idxNext;
            cntReg   <= cntNext;
            rdReg    <= rdNext;
            if (accept) begin
                wdReg   <= iMUsiWd;
                adrsReg <= iMUsiAdrs;
            end
        end
    end

    assign oMUsiRd   = rdReg;
    assign oMUsiVd   = (stateReg == DONE) || (stateReg == ERR);
    assign oMUsiErr  = (stateReg == ERR);
    assign oMUsiBusy = (stateReg != IDLE);
    assign oSUsiWd   = wdReg;
    assign oSUsiAdrs = adrsReg;

endmodule
